// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: geometry, default thresholds,
// FSM state encodings and the status-flag bundle with its helper function.
package fifo_ctrl_pkg;

  localparam int MEM_LENGTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int CNT_WIDTH  = 4;
  localparam int PTR_WIDTH  = $clog2(MEM_LENGTH);

  localparam logic [CNT_WIDTH-1:0] AF_DEFAULT = CNT_WIDTH'(6);
  localparam logic [CNT_WIDTH-1:0] AE_DEFAULT = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL   = CNT_WIDTH'(MEM_LENGTH);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

  localparam status_t STATUS_RESET = '{full: 1'b0, empty: 1'b1,
                                       almost_full: 1'b0, almost_empty: 1'b1};

  function automatic status_t calc_flags(input logic [CNT_WIDTH-1:0] cnt,
                                         input logic [CNT_WIDTH-1:0] af,
                                         input logic [CNT_WIDTH-1:0] ae);
    status_t s;
    s.full         = (cnt == CNT_FULL);
    s.empty        = (cnt == '0);
    s.almost_full  = (cnt >= af);
    s.almost_empty = (cnt <= ae);
    return s;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Requester/memory-side bundle of the FIFO controller.
//   master : requester side (drives init, thresholds, push, pop)
//   slave  : fifo_ctrl side (drives memory strobes/addresses and status)
interface fifo_ctrl_if;
  import fifo_ctrl_pkg::*;

  logic                  init;
  logic [CNT_WIDTH-1:0]  af_thresh_in;
  logic [CNT_WIDTH-1:0]  ae_thresh_in;
  logic                  push;
  logic                  pop;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  pop_valid;
  logic [CNT_WIDTH-1:0]  count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;
  logic                  idle;

  modport master (
    output init, af_thresh_in, ae_thresh_in, push, pop,
    input  write_enable, write_addr, read_enable, read_addr, pop_valid,
           count, full, empty, almost_full, almost_empty, fifo_error, idle
  );

  modport slave (
    input  init, af_thresh_in, ae_thresh_in, push, pop,
    output write_enable, write_addr, read_enable, read_addr, pop_valid,
           count, full, empty, almost_full, almost_empty, fifo_error, idle
  );

endinterface

// File: rtl/fifo_ctrl_ptr.sv
// Wrapping FIFO pointer. Advances by one on inc_i, returns to 0 on clr_i or
// reset. Wraps naturally because MEM_LENGTH is a power of two.
//   clk, reset_L : clock, synchronous active-low reset
//   clr_i        : synchronous clear (wins over inc_i)
//   inc_i        : advance pointer
//   ptr_o        : current pointer value
module fifo_ctrl_ptr
  import fifo_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [PTR_WIDTH-1:0] ptr_o
);

  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + PTR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Control and addressing for an 8 x 10 dual-port FIFO memory: turns push/pop
// strobes into memory enables/addresses, keeps occupancy and status flags,
// flags overflow/underflow, and holds programmable almost thresholds.
//   clk, reset_L : clock, synchronous active-low reset
//   bus (slave)  : init/thresholds/push/pop in; memory strobes, addresses,
//                  pop_valid, count, flags, fifo_error, idle out
//
// state  | meaning
// RESET  | held in reset, everything cleared
// INIT   | thresholds loaded every cycle, pointers/count/error cleared
// IDLE   | empty and error-free, waiting for a push
// ACTIVE | holds data, push/pop serviced
// ERROR  | overflow/underflow seen; ops blocked until init or reset
module fifo_ctrl
  import fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_L,
  fifo_ctrl_if.slave bus
);

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] af_q, af_d, ae_q, ae_d;
  status_t              flags_q, flags_d;
  logic                 err_q, err_d;
  logic                 pop_valid_q;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                 op_en, push_acc, pop_acc, overflow, underflow, ptr_clr;

  // Ops are blocked while init is high so nothing is written into a FIFO
  // that is about to be cleared.
  assign op_en     = reset_L & ~bus.init &
                     ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));
  assign push_acc  = op_en & bus.push & (~flags_q.full | bus.pop);
  assign pop_acc   = op_en & bus.pop & ~flags_q.empty;
  assign overflow  = op_en & bus.push & flags_q.full & ~bus.pop;
  // Push alongside an empty pop is still accepted; only the pop is refused.
  assign underflow = op_en & bus.pop & flags_q.empty;
  assign ptr_clr   = (state_q == ST_INIT) | (state_q == ST_RESET);

  fifo_ctrl_ptr u_wr_ptr (
    .clk    (clk),
    .reset_L(reset_L),
    .clr_i  (ptr_clr),
    .inc_i  (push_acc),
    .ptr_o  (wr_ptr)
  );

  fifo_ctrl_ptr u_rd_ptr (
    .clk    (clk),
    .reset_L(reset_L),
    .clr_i  (ptr_clr),
    .inc_i  (pop_acc),
    .ptr_o  (rd_ptr)
  );

  always_comb begin
    state_d = state_q;
    af_d    = af_q;
    ae_d    = ae_q;
    err_d   = err_q;
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
        count_d = '0;
      end
      ST_INIT: begin
        af_d    = bus.af_thresh_in;
        ae_d    = bus.ae_thresh_in;
        count_d = '0;
        err_d   = 1'b0;
        if (!bus.init) state_d = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE, ST_ERROR: begin
        if (bus.init) begin
          state_d = ST_INIT;
        end else if (overflow | underflow) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else if ((state_q == ST_IDLE) && push_acc) begin
          state_d = ST_ACTIVE;
        end else if ((state_q == ST_ACTIVE) && (count_d == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase

    flags_d = calc_flags(count_d, af_d, ae_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q     <= ST_RESET;
      count_q     <= '0;
      af_q        <= AF_DEFAULT;
      ae_q        <= AE_DEFAULT;
      flags_q     <= STATUS_RESET;
      err_q       <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      pop_valid_q <= pop_acc;
    end
  end

  assign bus.write_enable = push_acc;
  assign bus.read_enable  = pop_acc;
  assign bus.write_addr   = {{(ADDR_WIDTH-PTR_WIDTH){1'b0}}, wr_ptr};
  assign bus.read_addr    = {{(ADDR_WIDTH-PTR_WIDTH){1'b0}}, rd_ptr};
  assign bus.pop_valid    = pop_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.fifo_error   = err_q;
  assign bus.idle         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L, init, push, pop;
  logic [3:0] af_in, ae_in;
  logic [9:0] wdata;
  bit         chk_en = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  fifo_ctrl_if bus();
  assign bus.init         = init;
  assign bus.af_thresh_in = af_in;
  assign bus.ae_thresh_in = ae_in;
  assign bus.push         = push;
  assign bus.pop          = pop;

  fifo_ctrl dut (.clk(clk), .reset_L(reset_L), .bus(bus.slave));

  // Stand-in for the dual-port memory the controller addresses.
  logic [9:0] mem [0:7];
  logic [9:0] rdata = '0;
  always @(posedge clk) begin
    if (bus.write_enable) mem[bus.write_addr[2:0]] <= wdata;
    if (bus.read_enable)  rdata <= mem[bus.read_addr[2:0]];
  end

  // Behavioural reference: phase + data queue + pointer counters.
  localparam int P_RST = 0, P_INIT = 1, P_RUN = 2, P_ERR = 3;
  int         m_phase = P_RST;
  logic [9:0] m_q[$];
  int         m_wp = 0, m_rp = 0, m_af = 6, m_ae = 2;
  bit         m_err = 1'b0, m_pv = 1'b0;
  logic [9:0] m_rd = '0;
  int         m_sz;
  bit         m_pa, m_pp, m_ov, m_un;

  always @(posedge clk) begin
    if (!reset_L) begin
      m_phase = P_RST; m_q.delete(); m_wp = 0; m_rp = 0;
      m_err = 1'b0; m_pv = 1'b0; m_af = 6; m_ae = 2;
    end else begin
      case (m_phase)
        P_RST: begin m_phase = P_INIT; m_pv = 1'b0; end
        P_INIT: begin
          m_af = int'(af_in); m_ae = int'(ae_in);
          m_q.delete(); m_wp = 0; m_rp = 0; m_err = 1'b0; m_pv = 1'b0;
          if (!init) m_phase = P_RUN;
        end
        P_RUN: begin
          if (init) begin
            m_phase = P_INIT; m_pv = 1'b0;
          end else begin
            m_sz = m_q.size();
            m_pa = push && (m_sz < 8 || pop);
            m_pp = pop && m_sz > 0;
            m_ov = push && m_sz == 8 && !pop;
            m_un = pop && m_sz == 0;
            if (m_pp) begin m_rd = m_q.pop_front(); m_rp = (m_rp + 1) % 8; end
            if (m_pa) begin m_q.push_back(wdata); m_wp = (m_wp + 1) % 8; end
            m_pv = m_pp;
            if (m_ov || m_un) begin m_err = 1'b1; m_phase = P_ERR; end
          end
        end
        default: begin m_pv = 1'b0; if (init) m_phase = P_INIT; end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin : cmp
      int sz;
      bit run_ok;
      sz = m_q.size();
      run_ok = reset_L && (m_phase == P_RUN) && !init;
      check("count", bus.count, sz);
      check("full", bus.full, sz == 8);
      check("empty", bus.empty, sz == 0);
      check("almost_full", bus.almost_full, sz >= m_af);
      check("almost_empty", bus.almost_empty, sz <= m_ae);
      check("fifo_error", bus.fifo_error, m_err);
      check("idle", bus.idle, (m_phase == P_RUN) && sz == 0);
      check("pop_valid", bus.pop_valid, m_pv);
      check("write_addr", bus.write_addr, m_wp);
      check("read_addr", bus.read_addr, m_rp);
      check("write_enable", bus.write_enable, run_ok && push && (sz < 8 || pop));
      check("read_enable", bus.read_enable, run_ok && pop && sz > 0);
      if (m_pv) check("read_data", rdata, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_init(input logic [3:0] af, input logic [3:0] ae);
    push = 1'b0; pop = 1'b0; init = 1'b1; af_in = af; ae_in = ae;
    tick(); tick();
    init = 1'b0;
    tick();
  endtask

  int pp_pct, qp_pct, r;

  initial begin
    reset_L = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0;
    af_in = 4'd6; ae_in = 4'd2; wdata = '0;
    tick(); chk_en = 1'b1;
    tick(); tick();
    check("lit_rst_count", bus.count, 0);
    check("lit_rst_empty", bus.empty, 1);
    check("lit_rst_ae", bus.almost_empty, 1);
    check("lit_rst_full", bus.full, 0);
    check("lit_rst_err", bus.fifo_error, 0);
    check("lit_rst_idle", bus.idle, 0);
    push = 1'b1; #2 check("lit_rst_we", bus.write_enable, 0); push = 1'b0;

    reset_L = 1'b1; init = 1'b1;
    tick(); tick(); tick();
    init = 1'b0; tick();
    check("lit_init_idle", bus.idle, 1);
    check("lit_init_waddr", bus.write_addr, 0);
    check("lit_init_raddr", bus.read_addr, 0);

    push = 1'b1; wdata = 10'h091; #2 check("lit_we0", bus.write_enable, 1);
    check("lit_waddr0", bus.write_addr, 0); tick();
    wdata = 10'h04A; #2 check("lit_waddr1", bus.write_addr, 1); tick();
    check("lit_active", bus.idle, 0);
    check("lit_ae_at2", bus.almost_empty, 1);
    wdata = 10'h093; #2 check("lit_waddr2", bus.write_addr, 2); tick();
    push = 1'b0;
    check("lit_count3", bus.count, 3);
    check("lit_ae_at3", bus.almost_empty, 0);
    pop = 1'b1; #2 check("lit_re", bus.read_enable, 1);
    check("lit_raddr0", bus.read_addr, 0); tick();
    pop = 1'b0;
    check("lit_pv", bus.pop_valid, 1);
    check("lit_rdata", rdata, 10'h091);
    check("lit_count2", bus.count, 2);
    pop = 1'b1; tick(); tick(); pop = 1'b0;
    check("lit_drained_idle", bus.idle, 1);

    for (int k = 0; k < 8; k++) begin
      push = 1'b1; wdata = 10'($urandom); tick();
      if (k == 4) check("lit_af_at5", bus.almost_full, 0);
      if (k == 5) check("lit_af_at6", bus.almost_full, 1);
    end
    check("lit_full", bus.full, 1);
    pop = 1'b1; wdata = 10'h155; #2 check("lit_both_we", bus.write_enable, 1);
    check("lit_both_re", bus.read_enable, 1); tick();
    check("lit_both_count", bus.count, 8);
    pop = 1'b0; #2 check("lit_ovf_we", bus.write_enable, 0); tick();
    check("lit_ovf_err", bus.fifo_error, 1);
    #2 check("lit_err_we", bus.write_enable, 0); tick();
    push = 1'b0;
    init = 1'b1; tick(); init = 1'b0; tick();
    check("lit_clr_err", bus.fifo_error, 0);
    check("lit_clr_count", bus.count, 0);

    for (int k = 0; k < 7; k++) begin push = 1'b1; wdata = 10'($urandom); tick(); end
    push = 1'b0;
    for (int k = 0; k < 7; k++) begin pop = 1'b1; tick(); end
    pop = 1'b0;
    check("lit_wrap_idle", bus.idle, 1);
    push = 1'b1; wdata = 10'h2A5; #2 check("lit_waddr7", bus.write_addr, 7); tick();
    push = 1'b0;
    check("lit_wrap_waddr", bus.write_addr, 0);
    pop = 1'b1; tick(); pop = 1'b0;
    check("lit_wrap_raddr", bus.read_addr, 0);
    check("lit_wrap_rdata", rdata, 10'h2A5);

    push = 1'b1; pop = 1'b1; wdata = 10'h0F0; tick();
    push = 1'b0; pop = 1'b0;
    check("lit_unf_count", bus.count, 1);
    check("lit_unf_err", bus.fifo_error, 1);
    init = 1'b1; tick(); init = 1'b0; tick();
    check("lit_unf_clr", bus.fifo_error, 0);
    check("lit_unf_idle", bus.idle, 1);

    for (int k = 0; k < 5; k++) begin push = 1'b1; wdata = 10'($urandom); tick(); end
    check("lit_count5", bus.count, 5);
    reset_L = 1'b0; #2 check("lit_rst_mid_we", bus.write_enable, 0); tick();
    push = 1'b0;
    check("lit_rst_mid_count", bus.count, 0);
    check("lit_rst_mid_empty", bus.empty, 1);
    reset_L = 1'b1; tick(); tick();

    pp_pct = 60; qp_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        pp_pct = $urandom_range(20, 90);
        qp_pct = $urandom_range(20, 90);
      end
      r = $urandom_range(0, 999);
      if (r < 3) begin
        reset_L = 1'b0; push = 1'($urandom); pop = 1'($urandom); tick();
        reset_L = 1'b1; push = 1'b0; pop = 1'b0; tick();
        do_init(4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)));
      end else if (r < 25) begin
        do_init(4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)));
      end else begin
        push  = ($urandom_range(0, 99) < pp_pct);
        pop   = ($urandom_range(0, 99) < qp_pct);
        wdata = 10'($urandom);
        tick();
      end
    end
    push = 1'b0; pop = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control and addressing block for the 8-entry x 10-bit dual-port FIFO memory.
- Turns requester push/pop strobes into write_enable/read_enable and write_addr/read_addr for the memory.
- Keeps the fill count and full/empty/almost flags, and detects overflow/underflow.
- Holds programmable almost-full/almost-empty thresholds loaded during an INIT phase; sits between the requester logic and the memory instance.

Parameters:
- MEM_LENGTH, 8, number of memory rows (power of two).
- ADDR_WIDTH, 4, width of memory address ports; pointers use the low log2(MEM_LENGTH)=3 bits, upper bits driven 0.
- CNT_WIDTH, 4, fill-count width (holds 0..MEM_LENGTH).
- AF_DEFAULT, 6, almost-full threshold after reset.
- AE_DEFAULT, 2, almost-empty threshold after reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_L  in  1  synchronous active-low reset.
- init  in  1  when high in any non-RESET state, enter INIT and (re)load thresholds.
- af_thresh_in  in  CNT_WIDTH  almost-full threshold, sampled in INIT.
- ae_thresh_in  in  CNT_WIDTH  almost-empty threshold, sampled in INIT.
- push  in  1  requester write strobe.
- pop  in  1  requester read strobe.
- write_enable  out  1  memory write strobe (combinational, = accepted push).
- write_addr  out  ADDR_WIDTH  memory write address (= wr_ptr).
- read_enable  out  1  memory read strobe (combinational, = accepted pop).
- read_addr  out  ADDR_WIDTH  memory read address (= rd_ptr).
- pop_valid  out  1  registered; high the cycle after an accepted pop (memory data valid).
- count  out  CNT_WIDTH  current occupancy.
- full, empty, almost_full, almost_empty  out  1  status flags (registered).
- fifo_error  out  1  sticky overflow/underflow flag.
- idle  out  1  high in IDLE state.

Behaviour:
- Reset (reset_L=0 at posedge):
  - state=RESET; wr_ptr=rd_ptr=0; count=0.
  - empty=1, almost_empty=1; full=almost_full=0.
  - fifo_error=0, pop_valid=0, idle=0.
  - thresholds = AF_DEFAULT/AE_DEFAULT.
  - write_enable/read_enable forced 0 while reset_L=0.
  - Reset mid-operation discards all contents.
- State machine (registered):
  - RESET -> INIT on first cycle with reset_L=1.
  - INIT: load af/ae thresholds from inputs each cycle; pointers, count and error cleared; push/pop ignored; -> IDLE when init=0.
  - IDLE: count==0 and no error; idle=1; -> ACTIVE when push accepted.
  - ACTIVE: -> IDLE when count becomes 0; -> ERROR on overflow/underflow.
  - ERROR: fifo_error=1 held; push/pop ignored (enables 0); exits only via init (-> INIT) or reset.
  - init=1 from IDLE/ACTIVE/ERROR -> INIT next cycle.
- Accept rules (IDLE/ACTIVE only):
  - push_acc = push & (!full | pop).
  - pop_acc = pop & !empty.
- Pointer and count update on posedge:
  - wr_ptr += push_acc; rd_ptr += pop_acc; both wrap MEM_LENGTH-1 -> 0.
  - count += push_acc - pop_acc.
- Simultaneous push+pop:
  - Non-empty, non-full: both accepted, count unchanged.
  - Full: both accepted, full stays 1.
  - Empty: push accepted, pop rejected -> underflow.
- Errors:
  - Overflow = push & full & !pop.
  - Underflow = pop & empty.
  - Either sets fifo_error at next edge and moves to ERROR; the offending op is not performed.
- Flags from next count:
  - full = (count==MEM_LENGTH); empty = (count==0).
  - almost_full = (count>=af_thresh); almost_empty = (count<=ae_thresh).
- Latency:
  - Write occurs at the posedge where push_acc=1.
  - Read data is valid on the memory output one cycle after read_enable, flagged by pop_valid.

Decomposition:
- Shared package/header fifo_defs: state encodings (RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4), MEM_LENGTH, default thresholds.
- One natural sub-module: fifo_ptr (wrapping pointer with increment enable and clear), instantiated twice for wr_ptr and rd_ptr.

Test Plan:
- Reset, then init=1 with af=6, ae=2 for 2 cycles, then init=0 -> state IDLE, empty=1, almost_empty=1, count=0, write_addr=read_addr=0.
- Push 3 words (0x091, 0x04A, 0x093) on consecutive cycles -> write_addr 0,1,2 with write_enable=1; count=3; almost_empty drops after the 3rd push; state ACTIVE. Then pop once -> read_addr=0, pop_valid the next cycle, memory out 0x091, count=2.
- Push 8 from empty -> full=1 after the 8th, almost_full=1 from count=6. Then push+pop together -> both enables 1, count stays 8. Push alone -> fifo_error=1, state ERROR, write_enable=0.
- Fill to 7, drain to 0, push again -> wr_ptr wraps 7->0 and rd_ptr wraps correctly; data order preserved; state returns to IDLE at count=0.
- Pop when empty, with push asserted simultaneously -> push accepted (count=1), underflow flags fifo_error=1. Then init pulse -> error cleared, count=0, IDLE.
- Assert reset_L=0 with count=5 mid-stream -> next edge count=0, empty=1, all enables 0, state RESET.
